mips_main_control: RTL and testbench



---
 rtl/mips_pkg.sv | 51 +++++
 rtl/mips_control_decode.sv | 52 +++++
 rtl/mips_main_control.sv | 54 +++++
 tb/tb_mips_main_control.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS main control path: opcodes, ALUOp classes
// and the packed control bundle passed from decoder to output register.
package mips_pkg;

    localparam int OPCODE_W = 6;
    localparam int ALUOP_W  = 2;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;

    typedef struct packed {
        logic               reg_dst;
        logic               alu_src;
        logic               mem_to_reg;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               branch_eq;
        logic               branch_ne;
        logic               jump;
        logic [ALUOP_W-1:0] alu_op;
        logic               illegal_op;
    } ctrl_t;

    // All-quiet bundle: used for reset and as the base every decode starts from.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c.reg_dst    = 1'b0;
        c.alu_src    = 1'b0;
        c.mem_to_reg = 1'b0;
        c.reg_write  = 1'b0;
        c.mem_read   = 1'b0;
        c.mem_write  = 1'b0;
        c.branch_eq  = 1'b0;
        c.branch_ne  = 1'b0;
        c.jump       = 1'b0;
        c.alu_op     = ALUOP_ADD;
        c.illegal_op = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/mips_control_decode.sv
// Combinational opcode-to-control decoder. Unknown or unsupported opcodes
// (including X/Z) fall into the default branch and decode as an illegal NOP.
module mips_control_decode
    import mips_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_t               ctrl
);

    always_comb begin
        ctrl = ctrl_idle();
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_RTYPE;
            end
            OP_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
            end
            OP_BEQ: begin
                ctrl.branch_eq = 1'b1;
                ctrl.alu_op    = ALUOP_SUB;
            end
            OP_BNE: begin
                ctrl.branch_ne = 1'b1;
                ctrl.alu_op    = ALUOP_SUB;
            end
            OP_ADDI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            default: begin
                ctrl.illegal_op = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mips_main_control.sv
// MIPS main control unit: decodes the opcode and registers the control
// strobes, giving a fixed one-cycle latency from opcode to outputs.
module mips_main_control
    import mips_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                branch_eq,
    output logic                branch_ne,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                memRead,
    output logic                memWrite,
    output logic                memToReg,
    output logic                regDst,
    output logic                regWrite,
    output logic                ALUSrc,
    output logic                jump,
    output logic                illegal_op
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    mips_control_decode u_decode (
        .opcode (opcode),
        .ctrl   (ctrl_d)
    );

    // Reset wins over decode so a mid-stream reset clears outputs on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= ctrl_idle();
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign regDst     = ctrl_q.reg_dst;
    assign ALUSrc     = ctrl_q.alu_src;
    assign memToReg   = ctrl_q.mem_to_reg;
    assign regWrite   = ctrl_q.reg_write;
    assign memRead    = ctrl_q.mem_read;
    assign memWrite   = ctrl_q.mem_write;
    assign branch_eq  = ctrl_q.branch_eq;
    assign branch_ne  = ctrl_q.branch_ne;
    assign jump       = ctrl_q.jump;
    assign ALUOp      = ctrl_q.alu_op;
    assign illegal_op = ctrl_q.illegal_op;

endmodule

// File: tb/tb_mips_main_control.sv
// Bench for mips_main_control: directed plan steps plus a random opcode/reset
// stream, checked against a table-driven reference of the decode rules.
module tb_mips_main_control;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       branch_eq, branch_ne, memRead, memWrite, memToReg;
    logic       regDst, regWrite, ALUSrc, jump, illegal_op;
    logic [1:0] ALUOp;

    int n_tests;
    int n_fail;

    // Packed view, field order: regDst,ALUSrc,memToReg,regWrite,memRead,
    // memWrite,branch_eq,branch_ne,jump,ALUOp[1:0],illegal_op
    logic [11:0] exp_q[$];

    mips_main_control dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .branch_eq  (branch_eq),
        .branch_ne  (branch_ne),
        .ALUOp      (ALUOp),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .memToReg   (memToReg),
        .regDst     (regDst),
        .regWrite   (regWrite),
        .ALUSrc     (ALUSrc),
        .jump       (jump),
        .illegal_op (illegal_op)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference decode table written straight from the instruction list.
    logic [5:0]  ref_op  [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                 6'b000101, 6'b001000, 6'b000010};
    logic [11:0] ref_val [7] = '{12'b1_0_0_1_0_0_0_0_0_10_0,
                                 12'b0_1_1_1_1_0_0_0_0_00_0,
                                 12'b0_1_0_0_0_1_0_0_0_00_0,
                                 12'b0_0_0_0_0_0_1_0_0_01_0,
                                 12'b0_0_0_0_0_0_0_1_0_01_0,
                                 12'b0_1_0_1_0_0_0_0_0_00_0,
                                 12'b0_0_0_0_0_0_0_0_1_00_0};

    function automatic logic [11:0] model(input logic [5:0] op, input logic r);
        if (r) return 12'd0;
        for (int i = 0; i < 7; i++)
            if (ref_op[i] == op) return ref_val[i];
        return 12'b0_0_0_0_0_0_0_0_0_00_1;
    endfunction

    function automatic logic [11:0] observed();
        return {regDst, ALUSrc, memToReg, regWrite, memRead, memWrite,
                branch_eq, branch_ne, jump, ALUOp, illegal_op};
    endfunction

    // scoreboard check
    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // driver: apply one opcode/reset for one edge, then check that edge's result
    task automatic step(input logic [5:0] op, input logic r);
        int n_jb;
        @(negedge clk);
        opcode = op;
        rst    = r;
        exp_q.push_back(model(op, r));
        @(posedge clk);
        #1;
        check($sformatf("decode op=%b rst=%b", op, r), observed(), exp_q.pop_front());
        n_jb = int'(branch_eq) + int'(branch_ne) + int'(jump);
        check("inv_one_ctrl_xfer", 12'(n_jb <= 1), 12'd1);
        check("inv_mem_excl", 12'(!(memRead && memWrite)), 12'd1);
        check("inv_mem_to_reg", 12'(!memToReg || (memRead && regWrite)), 12'd1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        opcode  = 6'b000000;

        // reset held two edges, then R-type decodes on first free edge
        step(6'b000000, 1'b1);
        step(6'b000000, 1'b1);
        step(6'b000000, 1'b0);

        step(6'b000010, 1'b0);   // j
        step(6'b100011, 1'b0);   // lw
        step(6'b101011, 1'b0);   // sw
        step(6'b000100, 1'b0);   // beq
        step(6'b000101, 1'b0);   // bne

        // back-to-back through every supported opcode, reset mid-sequence
        for (int i = 0; i < 7; i++) step(ref_op[i], 1'b0);
        for (int i = 0; i < 7; i++) step(ref_op[i], (i == 3) ? 1'b1 : 1'b0);

        step(6'b111111, 1'b0);
        step(6'b001100, 1'b0);

        for (int i = 0; i < 64; i++) step(6'(i), 1'b0);

        // random stream, mostly legal opcodes with occasional reset
        for (int i = 0; i < 300; i++) begin
            logic [5:0] op;
            if ($urandom_range(0, 1) == 0) op = ref_op[$urandom_range(0, 6)];
            else                           op = 6'($urandom_range(0, 63));
            step(op, ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end

        // report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
